writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stall  in  1  hold WB register contents.
REQ-004 SHALL have ports: flush  in  1  replace next WB entry with a bubble.
REQ-005 SHALL have ports: mem_valid  in  1  MEM stage holds an instruction.
REQ-006 SHALL have ports: mem_reg_write  in  1  instruction writes rd.
REQ-007 SHALL have ports: mem_rd  in  5  destination register.
REQ-008 SHALL have ports: mem_result_src  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-009 SHALL have ports: mem_alu_result  in  32  ALU result / load address.
REQ-010 SHALL have ports: mem_read_data  in  32  raw data-memory word.
REQ-011 SHALL have ports: mem_pc_plus4  in  32  link value.
REQ-012 SHALL have ports: mem_funct3  in  3  load type.
REQ-013 SHALL have ports: WE3  out  1, A3  out  5, WD3  out  32  register-file write port.
REQ-014 SHALL have ports: fwd_en  out  1, fwd_rd  out  5, fwd_data  out  32  forwarding to EX.
REQ-015 SHALL have ports: instret  out  64  retired-instruction count.

Function
REQ-016 SHALL capture all mem_* inputs into the WB register on each rising edge where stall=0 and flush=0; one-cycle latency from MEM to WE3.
REQ-017 SHALL load valid_q=0 on the edge where flush=1; flush takes priority over stall.
REQ-018 SHALL hold the WB register unchanged on each edge where stall=1 and flush=0.
REQ-019 SHALL select the result as: 00 alu_q; 01 aligned load; 10 pc_plus4_q; 11 alu_q.
REQ-020 SHALL align loads by alu_q[1:0]: LB(000)/LBU(100) take byte alu_q[1:0], sign-/zero-extended; LH(001)/LHU(101) take the halfword selected by alu_q[1], sign-/zero-extended; LW(010) and all other codes take the full word.
REQ-021 SHALL drive WE3 = valid_q & reg_write_q & (rd_q != 0) & ~done_q, A3 = rd_q, WD3 = selected result.
REQ-022 SHALL set done_q the cycle after WE3 is asserted, so a stalled entry writes exactly once; done_q SHALL clear on every new capture.
REQ-023 SHALL drive fwd_en = valid_q & reg_write_q & (rd_q != 0), independent of done_q; fwd_rd = rd_q; fwd_data = WD3.
REQ-024 SHALL increment instret by 1 on each edge that captures mem_valid=1 with stall=0 and flush=0; it wraps from 2^64-1 to 0.
REQ-025 SHALL never assert WE3 or fwd_en for rd=0, even when reg_write_q=1.

Reset
REQ-026 SHALL, on an edge with rst=1, clear valid_q, done_q, every WB-register field, and instret to 0; this overrides stall and flush.
REQ-027 SHALL hold WE3=0, A3=0, WD3=0, fwd_en=0, fwd_rd=0, fwd_data=0 and instret=0 in the cycle after reset.
REQ-028 SHALL discard an entry held under stall when reset asserts; no write occurs for it.

Structure
REQ-029 SHALL take the result_src encodings and load funct3 codes from the shared package riscv_pkg.
REQ-030 SHALL place the combinational load alignment and extension in one sub-module, load_align_unit.

Verification
REQ-031 SHALL cover: LB, alu=0x1003, read_data=0x80FF_FF12, rd=5 -> next cycle WE3=1, A3=5, WD3=0xFFFF_FF80.
REQ-032 SHALL cover: LHU, alu=0x2002, read_data=0xBEEF_1234, rd=7 -> WD3=0x0000_BEEF.
REQ-033 SHALL cover: JAL, result_src=10, pc_plus4=0x0000_0104, rd=1, then stall held 3 cycles -> WE3=1 for exactly one cycle; fwd_en=1 for all 4 cycles; instret +1 only.
REQ-034 SHALL cover: ALU op with rd=0, result 0x1234 -> WE3=0 and fwd_en=0; instret still increments.
REQ-035 SHALL cover: flush=1 together with stall=1 while mem_valid=1 -> next cycle WE3=0 and fwd_en=0; instret unchanged.
REQ-036 SHALL cover: instret preset to 0xFFFF_FFFF_FFFF_FFFF (forced), one valid capture -> instret=0; then rst=1 mid-stall -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and the writeback pipeline-register layout.
package riscv_pkg;

  // Writeback result source select.
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_RSVD = 2'b11;

  // Load funct3 codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One WB pipeline-register entry as captured from the MEM stage.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  result_src;
    logic [31:0] alu;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [2:0]  funct3;
  } wb_entry_t;

endpackage

// File: rtl/load_align_unit.sv
// Combinational load alignment: picks the addressed byte/halfword out of
// the raw memory word and sign- or zero-extends it to 32 bits.
module load_align_unit
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = data_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = data_i[7:0];
      2'd1: byte_sel = data_i[15:8];
      2'd2: byte_sel = data_i[23:16];
      2'd3: byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
  end

  // Extend according to the load type; unknown codes pass the full word.
  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      F3_LW:   data_o = data_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: WB pipeline register with stall/flush, result selection,
// register-file write port (written once per entry), EX forwarding and a
// 64-bit retired-instruction counter.
module writeback_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_read_data,
  input  logic [31:0] mem_pc_plus4,
  input  logic [2:0]  mem_funct3,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        fwd_en,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [63:0] instret
);

  wb_entry_t   entry_q, entry_d;
  logic        done_q, done_d;
  logic [63:0] instret_q, instret_d;

  logic [31:0] load_data;
  logic [31:0] result;
  logic        writes_rd;

  load_align_unit u_load_align (
    .funct3_i  (entry_q.funct3),
    .addr_lo_i (entry_q.alu[1:0]),
    .data_i    (entry_q.read_data),
    .data_o    (load_data)
  );

  // Result mux; the reserved encoding falls back to the ALU value.
  always_comb begin
    result = entry_q.alu;
    case (entry_q.result_src)
      RES_ALU:  result = entry_q.alu;
      RES_LOAD: result = load_data;
      RES_PC4:  result = entry_q.pc_plus4;
      RES_RSVD: result = entry_q.alu;
      default:  result = entry_q.alu;
    endcase
  end

  // x0 is never a real destination, so it neither writes nor forwards.
  assign writes_rd = entry_q.valid & entry_q.reg_write & (entry_q.rd != 5'd0);

  assign WE3      = writes_rd & ~done_q;
  assign A3       = entry_q.rd;
  assign WD3      = result;
  assign fwd_en   = writes_rd;
  assign fwd_rd   = entry_q.rd;
  assign fwd_data = result;
  assign instret  = instret_q;

  // Next-state: flush bubbles, stall holds (remembering a completed write),
  // otherwise capture from MEM and count a retiring instruction.
  always_comb begin
    entry_d   = entry_q;
    done_d    = done_q;
    instret_d = instret_q;
    if (flush) begin
      entry_d.valid = 1'b0;
      done_d        = 1'b0;
    end else if (stall) begin
      done_d = done_q | WE3;
    end else begin
      entry_d.valid      = mem_valid;
      entry_d.reg_write  = mem_reg_write;
      entry_d.rd         = mem_rd;
      entry_d.result_src = mem_result_src;
      entry_d.alu        = mem_alu_result;
      entry_d.read_data  = mem_read_data;
      entry_d.pc_plus4   = mem_pc_plus4;
      entry_d.funct3     = mem_funct3;
      done_d             = 1'b0;
      instret_d          = instret_q + {63'd0, mem_valid};
    end
  end

  // State registers; reset wins over stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q   <= '0;
      done_q    <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      entry_q   <= entry_d;
      done_q    <= done_d;
      instret_q <= instret_d;
    end
  end

endmodule
